// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared state type and constants for the delay-timer monitor
package delay_timer_pkg;
    localparam int CNT_W_DEF = 16;
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_ANY = 2'b10;
    typedef enum logic [2:0] {IDLE, WAIT_TRIG, WAIT_ASSERT, WAIT_RELEASE, REPORT} mon_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus a delayed flop giving level, rise and fall
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_q1, r_q2, r_q3;
    always_ff @(posedge clk) begin
        if (reset) {r_q1, r_q2, r_q3} <= {3{RST_VAL}};
        else {r_q1, r_q2, r_q3} <= {i_async, r_q1, r_q2};
    end
    // level comes from the third flop, so a level test lags the matching edge by one cycle
    assign o_level = r_q3;
    assign o_rise = r_q2 & ~r_q3;
    assign o_fall = ~r_q2 & r_q3;
endmodule

// File: rtl/delay_timer_monitor.sv
// delay_timer_monitor: measures trigger-to-output delay and output-low width of a delay timer
module delay_timer_monitor
    import delay_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             delay_out_n,
    input  logic [1:0]       edge_sel,
    input  logic             arm,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_timeout,
    output logic             meas_overrun
);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MAX = '1;
    mon_state_t r_state, w_state_nxt;
    logic [1:0] r_sel;
    logic [CNT_W-1:0] r_dcnt, r_wcnt;
    logic w_trig_lvl, w_trig_rise, w_trig_fall;
    logic w_out_lvl, w_out_rise, w_out_fall;
    logic w_edge, w_unused;

    sync_edge_det #(.RST_VAL(1'b0)) u_trig (
        .clk(clk), .reset(reset), .i_async(trigger),
        .o_level(w_trig_lvl), .o_rise(w_trig_rise), .o_fall(w_trig_fall)
    );
    sync_edge_det #(.RST_VAL(1'b1)) u_out (
        .clk(clk), .reset(reset), .i_async(delay_out_n),
        .o_level(w_out_lvl), .o_rise(w_out_rise), .o_fall(w_out_fall)
    );

    assign w_unused = &{1'b0, w_trig_lvl, w_out_rise, w_out_fall};
    assign w_edge = r_sel == EDGE_FALL ? w_trig_fall :
                    r_sel == EDGE_ANY  ? (w_trig_rise | w_trig_fall) : w_trig_rise;
    assign busy = r_state != IDLE;
    assign meas_valid = r_state == REPORT;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:         w_state_nxt = arm ? WAIT_TRIG : IDLE;
            WAIT_TRIG:    w_state_nxt = !arm ? IDLE : w_edge ? WAIT_ASSERT : WAIT_TRIG;
            WAIT_ASSERT:  w_state_nxt = !w_out_lvl ? WAIT_RELEASE : r_dcnt == TO ? REPORT : WAIT_ASSERT;
            WAIT_RELEASE: w_state_nxt = w_out_lvl ? REPORT : WAIT_RELEASE;
            REPORT:       w_state_nxt = !meas_ready ? REPORT : arm ? WAIT_TRIG : IDLE;
            default:      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= EDGE_RISE;
            r_dcnt <= '0;
            r_wcnt <= '0;
            meas_delay <= '0;
            meas_width <= '0;
            meas_timeout <= 1'b0;
            meas_overrun <= 1'b0;
        end else begin
            if (r_state == IDLE && arm) r_sel <= edge_sel;
            if (r_state == WAIT_TRIG && arm && w_edge) begin
                r_dcnt <= '0;
                meas_overrun <= 1'b0;
            end
            // an extra selected edge while a measurement is in flight is flagged, not queued
            if ((r_state == WAIT_ASSERT || r_state == WAIT_RELEASE || r_state == REPORT) && w_edge)
                meas_overrun <= 1'b1;
            if (r_state == WAIT_ASSERT) begin
                if (!w_out_lvl) begin
                    meas_delay <= r_dcnt;
                    r_wcnt <= CNT_W'(1);
                end else if (r_dcnt == TO) begin
                    meas_delay <= TO;
                    meas_width <= '0;
                    meas_timeout <= 1'b1;
                end else r_dcnt <= r_dcnt + 1'b1;
            end
            if (r_state == WAIT_RELEASE) begin
                if (w_out_lvl) begin
                    meas_width <= r_wcnt;
                    meas_timeout <= 1'b0;
                end else if (r_wcnt != MAX) r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_delay_timer_monitor.sv
// tb_delay_timer_monitor: directed stimulus with a queued scoreboard checked by a monitor process
module tb_delay_timer_monitor;
    localparam int CNT_W = 16;
    typedef struct packed {
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] w;
        logic             t;
        logic             o;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, trigger = 1'b0, delay_out_n = 1'b1;
    logic [1:0] edge_sel = 2'b00;
    logic arm = 1'b0, meas_ready = 1'b1;
    logic busy, meas_valid, meas_timeout, meas_overrun;
    logic [CNT_W-1:0] meas_delay, meas_width;
    exp_t q[$];
    int comps = 0, errs = 0;

    delay_timer_monitor #(.CNT_W(CNT_W), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .delay_out_n(delay_out_n),
        .edge_sel(edge_sel), .arm(arm), .busy(busy), .meas_valid(meas_valid),
        .meas_ready(meas_ready), .meas_delay(meas_delay), .meas_width(meas_width),
        .meas_timeout(meas_timeout), .meas_overrun(meas_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!reset && meas_valid) begin
            comps++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_result: got delay=%0d width=%0d to=%0b ovr=%0b, required no result",
                         meas_delay, meas_width, meas_timeout, meas_overrun);
            end else if ({meas_delay, meas_width, meas_timeout, meas_overrun} != q[0]) begin
                errs++;
                $display("FAIL %s: got delay=%0d width=%0d to=%0b ovr=%0b, required delay=%0d width=%0d to=%0b ovr=%0b",
                         meas_ready ? "result" : "hold", meas_delay, meas_width, meas_timeout, meas_overrun,
                         q[0].d, q[0].w, q[0].t, q[0].o);
            end
            if (meas_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        comps++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int n);
        int k = 0;
        while (q.size() != 0 && k < n) begin
            tick(1);
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic rearm(input logic [1:0] sel, input logic trig);
        int k = 0;
        arm = 1'b0;
        tick(1);
        while (busy && k < 20) begin
            tick(1);
            k++;
        end
        chk("idle_before_arm", int'(busy), 0);
        trigger = trig;
        edge_sel = sel;
        arm = 1'b1;
        tick(5);
    endtask

    initial begin
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_delay", int'(meas_delay), 0);
        chk("rst_width", int'(meas_width), 0);
        chk("rst_timeout", int'(meas_timeout), 0);
        chk("rst_overrun", int'(meas_overrun), 0);
        reset = 1'b0;
        tick(2);

        rearm(2'b00, 1'b0);
        q.push_back('{d: 10, w: 20, t: 0, o: 0});
        trigger = 1'b1;
        tick(10);
        delay_out_n = 1'b0;
        tick(20);
        delay_out_n = 1'b1;
        drain("t1_drain", 20);

        rearm(2'b01, 1'b1);
        q.push_back('{d: 5, w: 7, t: 0, o: 0});
        trigger = 1'b0;
        tick(5);
        delay_out_n = 1'b0;
        tick(7);
        delay_out_n = 1'b1;
        drain("t2_drain", 20);

        rearm(2'b00, 1'b0);
        q.push_back('{d: 100, w: 0, t: 1, o: 0});
        trigger = 1'b1;
        drain("t3_drain", 150);

        rearm(2'b00, 1'b0);
        delay_out_n = 1'b0;
        tick(3);
        q.push_back('{d: 0, w: 4, t: 0, o: 0});
        trigger = 1'b1;
        tick(4);
        delay_out_n = 1'b1;
        drain("t4_drain", 20);

        meas_ready = 1'b0;
        rearm(2'b00, 1'b0);
        q.push_back('{d: 10, w: 20, t: 0, o: 1});
        trigger = 1'b1;
        tick(3);
        trigger = 1'b0;
        tick(7);
        delay_out_n = 1'b0;
        tick(5);
        trigger = 1'b1;
        tick(15);
        delay_out_n = 1'b1;
        for (int k = 0; k < 40 && !meas_valid; k++) tick(1);
        chk("t5_valid_seen", int'(meas_valid), 1);
        tick(50);
        chk("t5_valid_held", int'(meas_valid), 1);
        meas_ready = 1'b1;
        tick(1);
        chk("t5_valid_drop", int'(meas_valid), 0);
        chk("t5_drained", q.size(), 0);

        rearm(2'b00, 1'b0);
        trigger = 1'b1;
        tick(10);
        delay_out_n = 1'b0;
        tick(8);
        reset = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        delay_out_n = 1'b1;
        tick(1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(meas_valid), 0);
        chk("t6_delay", int'(meas_delay), 0);
        tick(2);
        reset = 1'b0;
        tick(4);
        rearm(2'b00, 1'b0);
        q.push_back('{d: 6, w: 3, t: 0, o: 0});
        trigger = 1'b1;
        tick(6);
        delay_out_n = 1'b0;
        tick(3);
        delay_out_n = 1'b1;
        drain("t6_drain", 20);
        arm = 1'b0;
        tick(10);
        chk("leftover", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end
endmodule
